asic_pad_ctrl: RTL

Parametrised pad-ring controller that sits between the core and the four-sided pad ring (west, north, south, east). It drives every pad's output data, output-enable, input-enable and technology configuration from a bank of per-pin registers written over a simple register port. It synchronises the pad inputs for readback and optionally raises a maskable rising-edge interrupt per pin. It generalises the fixed 9-pin, 16-bit-config per-side pad interface to any pin count and config width, adding run-time programmability.

---
 rtl/asic_pad_ctrl_if.sv | 27 ++
 rtl/asic_pad_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/asic_pad_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : asic_pad_ctrl_if
// Brief    : Register-port bundle for the pad-ring controller (request and
//            one-cycle-later response).
// Revision : 1.0 - initial release
// ============================================================================
interface asic_pad_ctrl_if;
  logic        reg_valid;
  logic        reg_write;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_rvalid;
  logic [31:0] reg_rdata;
  logic        reg_err;

  modport master (
    output reg_valid, reg_write, reg_addr, reg_wdata,
    input  reg_rvalid, reg_rdata, reg_err
  );

  modport slave (
    input  reg_valid, reg_write, reg_addr, reg_wdata,
    output reg_rvalid, reg_rdata, reg_err
  );
endinterface
`default_nettype wire

// File: rtl/asic_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : asic_pad_ctrl
// Brief    : Four-sided pad-ring controller with per-pin config registers,
//            synchronised input readback and optional rising-edge interrupts
//            (enabled by defining PADCTRL_IRQ_EN).
// Revision : 1.0 - initial release
// ============================================================================
module asic_pad_ctrl #(
  parameter int          PINS    = 9,
  parameter int          CFGW    = 16,
  parameter int          SYNC    = 2,
  parameter logic [31:0] RST_CFG = 32'h0
) (
  input  logic                   clk,
  input  logic                   nreset,
  asic_pad_ctrl_if.slave         reg_if,
  input  logic [4*PINS-1:0]      pad_din,
  output logic [4*PINS-1:0]      pad_dout,
  output logic [4*PINS-1:0]      pad_oen,
  output logic [4*PINS-1:0]      pad_ie,
  output logic [4*PINS*CFGW-1:0] pad_tech_cfg,
  output logic                   irq
);

  localparam int              c_NPIN    = 4 * PINS;
  localparam int              c_NWORD   = (c_NPIN + 31) / 32;
  localparam int              c_PADW    = c_NWORD * 32;
  localparam logic [CFGW-1:0] c_RST_CFG = RST_CFG[CFGW-1:0];

  // --------------------------------------------------------------------------
  // Address map
  // --------------------------------------------------------------------------
  function automatic logic in_bank(input logic [7:0] a, input logic [7:0] base);
    return (a >= base) && (32'(a - base) < c_NWORD);
  endfunction

  function automatic logic is_mapped(input logic [7:0] a);
    logic m;
    m = (32'(a) < c_NPIN) || in_bank(a, 8'h80);
`ifdef PADCTRL_IRQ_EN
    m = m || in_bank(a, 8'h88) || in_bank(a, 8'h90);
`endif
    return m;
  endfunction

  // --------------------------------------------------------------------------
  // Access capture: the response is built in the following cycle
  // --------------------------------------------------------------------------
  logic        w_wr;
  logic        r_rvalid;
  logic        r_write;
  logic        r_err;
  logic [7:0]  r_addr;
  logic [31:0] w_rdata;
  logic        w_unused_ok;

  assign w_wr        = reg_if.reg_valid & reg_if.reg_write;
  assign w_unused_ok = &{1'b0, reg_if.reg_wdata};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_rvalid <= 1'b0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
    end else begin
      r_rvalid <= reg_if.reg_valid;
      r_err    <= reg_if.reg_valid & ~is_mapped(reg_if.reg_addr);
      if (reg_if.reg_valid) begin
        r_write <= reg_if.reg_write;
        r_addr  <= reg_if.reg_addr;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-pin configuration flops; pads are driven straight from these
  // --------------------------------------------------------------------------
  logic [c_NPIN-1:0]           r_dout;
  logic [c_NPIN-1:0]           r_oen;
  logic [c_NPIN-1:0]           r_ie;
  logic [c_NPIN-1:0][CFGW-1:0] r_cfg;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_dout <= '0;
      r_oen  <= '1;
      r_ie   <= '1;
      r_cfg  <= {c_NPIN{c_RST_CFG}};
    end else if (w_wr) begin
      for (int i = 0; i < c_NPIN; i++) begin
        if (reg_if.reg_addr == 8'(i)) begin
          r_dout[i] <= reg_if.reg_wdata[0];
          r_oen[i]  <= reg_if.reg_wdata[1];
          r_ie[i]   <= reg_if.reg_wdata[2];
          r_cfg[i]  <= reg_if.reg_wdata[CFGW+2:3];
        end
      end
    end
  end

  assign pad_dout     = r_dout;
  assign pad_oen      = r_oen;
  assign pad_ie       = r_ie;
  assign pad_tech_cfg = r_cfg;

  // --------------------------------------------------------------------------
  // Input synchroniser; the last stage is the pin's sampled level
  // --------------------------------------------------------------------------
  logic [SYNC-1:0][c_NPIN-1:0] r_sync;
  logic [c_NPIN-1:0]           w_sync_din;
  logic [c_PADW-1:0]           w_din_pad;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC-2:0], pad_din};
    end
  end

  assign w_sync_din = r_sync[SYNC-1];
  assign w_din_pad  = c_PADW'(w_sync_din & r_ie);

  // --------------------------------------------------------------------------
  // Optional rising-edge interrupt
  // --------------------------------------------------------------------------
`ifdef PADCTRL_IRQ_EN
  logic [c_NPIN-1:0] r_prev;
  logic [c_NPIN-1:0] r_pend;
  logic [c_NPIN-1:0] r_mask;
  logic [c_NPIN-1:0] w_rise;
  logic [c_NPIN-1:0] w_w1c;
  logic [c_NPIN-1:0] w_mask_nxt;
  logic [c_PADW-1:0] w_pend_pad;
  logic [c_PADW-1:0] w_mask_pad;
  logic              r_irq;

  assign w_rise     = w_sync_din & ~r_prev & r_ie;
  assign w_pend_pad = c_PADW'(r_pend);
  assign w_mask_pad = c_PADW'(r_mask);

  always_comb begin
    w_w1c      = '0;
    w_mask_nxt = r_mask;
    for (int i = 0; i < c_NPIN; i++) begin
      if (w_wr && reg_if.reg_addr == 8'(32'h88 + i / 32)) begin
        w_w1c[i] = reg_if.reg_wdata[i % 32];
      end
      if (w_wr && reg_if.reg_addr == 8'(32'h90 + i / 32)) begin
        w_mask_nxt[i] = reg_if.reg_wdata[i % 32];
      end
    end
  end

  // A fresh edge overrides a clear of the same bit in the same cycle
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_prev <= '0;
      r_pend <= '0;
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_prev <= w_sync_din;
      r_pend <= (r_pend & ~w_w1c) | w_rise;
      r_mask <= w_mask_nxt;
      r_irq  <= |(r_pend & r_mask);
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Read response, decoded from the captured address against current state
  // --------------------------------------------------------------------------
  always_comb begin
    w_rdata = '0;
    if (r_rvalid && !r_write && !r_err) begin
      for (int i = 0; i < c_NPIN; i++) begin
        if (r_addr == 8'(i)) begin
          w_rdata = 32'({r_cfg[i], r_ie[i], r_oen[i], r_dout[i]});
        end
      end
      for (int k = 0; k < c_NWORD; k++) begin
        if (r_addr == 8'(32'h80 + k)) begin
          w_rdata = w_din_pad[k*32 +: 32];
        end
`ifdef PADCTRL_IRQ_EN
        if (r_addr == 8'(32'h88 + k)) begin
          w_rdata = w_pend_pad[k*32 +: 32];
        end
        if (r_addr == 8'(32'h90 + k)) begin
          w_rdata = w_mask_pad[k*32 +: 32];
        end
`endif
      end
    end
  end

  assign reg_if.reg_rvalid = r_rvalid;
  assign reg_if.reg_err    = r_err;
  assign reg_if.reg_rdata  = w_rdata;

endmodule
`default_nettype wire
